// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline stage register.
// Valid/ready handshake on both sides with an optional 2-entry skid buffer.
// Also provides a synchronous flush, a control bundle that is forced to zero
// during bubbles, and a saturating bubble counter.
// With SKID=1, in_ready is a flop, so there is no combinational path from
// out_ready to in_ready.
// With SKID=0, the stage holds a single entry. It can accept a new entry and
// drain the current one in the same cycle.
module mem_wb_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [RD_W-1:0]   rd,
  input  logic [CTRL_W-1:0] control_unit_signal,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] o_mem_read_data,
  output logic [DATA_W-1:0] o_alu_out,
  output logic [RD_W-1:0]   o_rd,
  output logic [CTRL_W-1:0] o_control_unit_signal,
  output logic [15:0]       o_bubble_cnt
);

  // Occupancy states: EMPTY (nothing held), HALF (main holds the output entry),
  // FULL (main and skid both hold entries).
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_HALF  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic              out_valid_r;
  logic              in_ready_r;
  logic              in_ready_s;
  logic              in_xfer_s;
  logic              load_main_in_s;
  logic              load_main_skid_s;
  logic              load_skid_s;
  logic [15:0]       bubble_cnt_r;

  logic [DATA_W-1:0] main_mem_r;
  logic [DATA_W-1:0] main_alu_r;
  logic [RD_W-1:0]   main_rd_r;
  logic [CTRL_W-1:0] main_ctrl_r;
  logic [DATA_W-1:0] skid_mem_r;
  logic [DATA_W-1:0] skid_alu_r;
  logic [RD_W-1:0]   skid_rd_r;
  logic [CTRL_W-1:0] skid_ctrl_r;

  // Select the ready source: a registered flop in skid mode, a combinational term otherwise.
  always_comb begin
    if (SKID != 0) begin
      in_ready_s = in_ready_r;
    end else begin
      in_ready_s = ~out_valid_r | out_ready;
    end
    in_xfer_s = in_valid & in_ready_s;
  end

  // Next-state and payload-load decisions. Flush overrides everything else.
  always_comb begin
    state_nxt_s      = state_r;
    load_main_in_s   = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    if (flush) begin
      state_nxt_s = ST_EMPTY;
    end else if (SKID != 0) begin
      case (state_r)
        ST_EMPTY: begin
          if (in_xfer_s) begin
            state_nxt_s    = ST_HALF;
            load_main_in_s = 1'b1;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_HALF: begin
          if (in_xfer_s && out_ready) begin
            state_nxt_s    = ST_HALF;
            load_main_in_s = 1'b1;
          end else if (in_xfer_s) begin
            state_nxt_s = ST_FULL;
            load_skid_s = 1'b1;
          end else if (out_ready) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_HALF;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            state_nxt_s      = ST_HALF;
            load_main_skid_s = 1'b1;
          end else begin
            state_nxt_s = ST_FULL;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
        end
      endcase
    end else begin
      if (in_xfer_s) begin
        state_nxt_s    = ST_HALF;
        load_main_in_s = 1'b1;
      end else if (out_ready) begin
        state_nxt_s = ST_EMPTY;
      end else begin
        state_nxt_s = state_r;
      end
    end
  end

  // Occupancy state and the registered handshake flags derived from it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      out_valid_r <= (state_nxt_s != ST_EMPTY);
      in_ready_r  <= (state_nxt_s != ST_FULL);
    end
  end

  // Main payload register. It loads only on a transfer and otherwise holds its value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_mem_r  <= {DATA_W{1'b0}};
      main_alu_r  <= {DATA_W{1'b0}};
      main_rd_r   <= {RD_W{1'b0}};
      main_ctrl_r <= {CTRL_W{1'b0}};
    end else if (load_main_in_s) begin
      main_mem_r  <= mem_read_data;
      main_alu_r  <= alu_out;
      main_rd_r   <= rd;
      main_ctrl_r <= control_unit_signal;
    end else if (load_main_skid_s) begin
      main_mem_r  <= skid_mem_r;
      main_alu_r  <= skid_alu_r;
      main_rd_r   <= skid_rd_r;
      main_ctrl_r <= skid_ctrl_r;
    end
  end

  // Skid payload register. It captures the overflow entry while the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_mem_r  <= {DATA_W{1'b0}};
      skid_alu_r  <= {DATA_W{1'b0}};
      skid_rd_r   <= {RD_W{1'b0}};
      skid_ctrl_r <= {CTRL_W{1'b0}};
    end else if (load_skid_s) begin
      skid_mem_r  <= mem_read_data;
      skid_alu_r  <= alu_out;
      skid_rd_r   <= rd;
      skid_ctrl_r <= control_unit_signal;
    end
  end

  // Saturating count of bubble cycles. Only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_r <= 16'd0;
    end else if (!out_valid_r && (bubble_cnt_r != 16'hFFFF)) begin
      bubble_cnt_r <= bubble_cnt_r + 16'd1;
    end
  end

  // Output assignments. The control bundle is gated so that a bubble can never
  // trigger a register write.
  always_comb begin
    in_ready        = in_ready_s;
    out_valid       = out_valid_r;
    o_mem_read_data = main_mem_r;
    o_alu_out       = main_alu_r;
    o_rd            = main_rd_r;
    o_bubble_cnt    = bubble_cnt_r;
    if (out_valid_r) begin
      o_control_unit_signal = main_ctrl_r;
    end else begin
      o_control_unit_signal = {CTRL_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Directed testbench for mem_wb_pipe_reg.
// It uses two instances: u_dut with a skid buffer and u_dut0 without one.
// Inputs are driven and outputs are sampled on the falling edge.
module tb_mem_wb_pipe_reg;

  logic        clk;
  logic        rst_n;
  int          errors = 0;
  int          checks = 0;

  // SKID=1 instance signals
  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] mem_read_data, alu_out, o_mem_read_data, o_alu_out;
  logic [4:0]  rd, o_rd;
  logic [7:0]  ctrl, o_ctrl;
  logic [15:0] bcnt;

  // SKID=0 instance signals
  logic        flush0, in_valid0, in_ready0, out_valid0, out_ready0;
  logic [31:0] mem_read_data0, alu_out0, o_mem_read_data0, o_alu_out0;
  logic [4:0]  rd0, o_rd0;
  logic [7:0]  ctrl0, o_ctrl0;
  logic [15:0] bcnt0;

  mem_wb_pipe_reg #(.DATA_W(32), .RD_W(5), .CTRL_W(8), .SKID(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .mem_read_data(mem_read_data), .alu_out(alu_out), .rd(rd),
    .control_unit_signal(ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .o_mem_read_data(o_mem_read_data), .o_alu_out(o_alu_out), .o_rd(o_rd),
    .o_control_unit_signal(o_ctrl), .o_bubble_cnt(bcnt)
  );

  mem_wb_pipe_reg #(.DATA_W(32), .RD_W(5), .CTRL_W(8), .SKID(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush0),
    .in_valid(in_valid0), .in_ready(in_ready0),
    .mem_read_data(mem_read_data0), .alu_out(alu_out0), .rd(rd0),
    .control_unit_signal(ctrl0),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .o_mem_read_data(o_mem_read_data0), .o_alu_out(o_alu_out0), .o_rd(o_rd0),
    .o_control_unit_signal(o_ctrl0), .o_bubble_cnt(bcnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      flush = 1'b0; in_valid = 1'($urandom); out_ready = 1'($urandom);
      alu_out = $urandom; mem_read_data = $urandom; rd = 5'($urandom); ctrl = 8'($urandom);
      flush0 = 1'b0; in_valid0 = 1'($urandom); out_ready0 = 1'($urandom);
      alu_out0 = $urandom; mem_read_data0 = $urandom; rd0 = 5'($urandom); ctrl0 = 8'($urandom);
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (o_ctrl !== 8'h00) begin errors++; $display("FAIL reset_ctrl got=%h exp=00", o_ctrl); end
    checks++; if (bcnt !== 16'd0) begin errors++; $display("FAIL reset_bcnt got=%0d exp=0", bcnt); end
    checks++; if (o_alu_out !== 32'd0) begin errors++; $display("FAIL reset_alu got=%h exp=0", o_alu_out); end
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL reset0_out_valid got=%b exp=0", out_valid0); end
    checks++; if (bcnt0 !== 16'd0) begin errors++; $display("FAIL reset0_bcnt got=%0d exp=0", bcnt0); end
    in_valid = 1'b0; out_ready = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0;
    rst_n = 1'b1;
  endtask

  // Idle for three cycles after reset. The bubble counter should reach 3.
  task automatic test_bubble();
    repeat (3) @(negedge clk);
    checks++; if (bcnt !== 16'd3) begin errors++; $display("FAIL bubble_cnt got=%0d exp=3", bcnt); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; alu_out = 32'(i); mem_read_data = 32'(i + 100); rd = 5'(i); ctrl = 8'(i);
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || o_alu_out !== 32'(i)) begin
        errors++; $display("FAIL stream_out[%0d] got valid=%b alu=%0d exp valid=1 alu=%0d", i, out_valid, o_alu_out, i);
      end
      checks++; if (o_mem_read_data !== 32'(i + 100) || o_rd !== 5'(i) || o_ctrl !== 8'(i)) begin
        errors++; $display("FAIL stream_payload[%0d] got mem=%0d rd=%0d ctrl=%0d", i, o_mem_read_data, o_rd, o_ctrl);
      end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, in_ready); end
    end
    checks++; if (bcnt !== 16'd4) begin errors++; $display("FAIL stream_bcnt got=%0d exp=4", bcnt); end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || o_ctrl !== 8'h00) begin
      errors++; $display("FAIL stream_drain got valid=%b ctrl=%h exp 0/00", out_valid, o_ctrl);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; alu_out = 32'h11; ctrl = 8'hA1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || o_alu_out !== 32'h11 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_half got valid=%b alu=%h rdy=%b exp 1/11/1", out_valid, o_alu_out, in_ready);
    end
    alu_out = 32'h22; ctrl = 8'hB2;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0 || o_alu_out !== 32'h11) begin
      errors++; $display("FAIL bp_full got rdy=%b alu=%h exp 0/11", in_ready, o_alu_out);
    end
    // While FULL, an offer with unknown payload must be ignored.
    alu_out = 'x; ctrl = 'x; mem_read_data = 'x;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0 || o_alu_out !== 32'h11 || o_ctrl !== 8'hA1) begin
      errors++; $display("FAIL bp_hold got rdy=%b alu=%h ctrl=%h exp 0/11/a1", in_ready, o_alu_out, o_ctrl);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || o_alu_out !== 32'h22 || o_ctrl !== 8'hB2 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_second got valid=%b alu=%h ctrl=%h rdy=%b exp 1/22/b2/1", out_valid, o_alu_out, o_ctrl, in_ready);
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || o_ctrl !== 8'h00) begin
      errors++; $display("FAIL bp_empty got valid=%b ctrl=%h exp 0/00", out_valid, o_ctrl);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; alu_out = 32'h44; ctrl = 8'h44;
    @(negedge clk);
    alu_out = 32'h55; ctrl = 8'h55;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_prefull got rdy=%b exp 0", in_ready); end
    flush = 1'b1; alu_out = 32'h33; ctrl = 8'h33;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || o_ctrl !== 8'h00 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_full got valid=%b ctrl=%h rdy=%b exp 0/00/1", out_valid, o_ctrl, in_ready);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_c got valid=%b alu=%h exp 0", out_valid, o_alu_out); end
    // Flush while HALF, with an accepted-looking offer in the same cycle.
    out_ready = 1'b0; in_valid = 1'b1; alu_out = 32'h66; ctrl = 8'h66;
    @(negedge clk);
    flush = 1'b1; alu_out = 32'h33; ctrl = 8'h33;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || o_ctrl !== 8'h00 || o_alu_out !== 32'h66) begin
      errors++; $display("FAIL flush_half got valid=%b ctrl=%h alu=%h exp 0/00/66", out_valid, o_ctrl, o_alu_out);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_half_after got valid=%b exp 0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; alu_out = 32'h77; ctrl = 8'h77;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL areset_pre got valid=%b exp 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || o_ctrl !== 8'h00) begin
      errors++; $display("FAIL areset_now got valid=%b rdy=%b ctrl=%h exp 0/1/00", out_valid, in_ready, o_ctrl);
    end
    checks++; if (bcnt !== 16'd0 || o_alu_out !== 32'd0) begin
      errors++; $display("FAIL areset_regs got bcnt=%0d alu=%h exp 0/0", bcnt, o_alu_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_skid0();
    in_valid0 = 1'b1; alu_out0 = 32'h71; ctrl0 = 8'h71; out_ready0 = 1'b0;
    #1;
    checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL s0_empty_rdy got=%b exp 1", in_ready0); end
    @(negedge clk);
    checks++; if (out_valid0 !== 1'b1 || o_alu_out0 !== 32'h71) begin
      errors++; $display("FAIL s0_first got valid=%b alu=%h exp 1/71", out_valid0, o_alu_out0);
    end
    alu_out0 = 32'h72; ctrl0 = 8'h72;
    #1;
    checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL s0_stall_rdy got=%b exp 0", in_ready0); end
    @(negedge clk);
    checks++; if (o_alu_out0 !== 32'h71 || o_ctrl0 !== 8'h71) begin
      errors++; $display("FAIL s0_hold got alu=%h ctrl=%h exp 71/71", o_alu_out0, o_ctrl0);
    end
    out_ready0 = 1'b1;
    #1;
    checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL s0_comb_rdy got=%b exp 1", in_ready0); end
    @(negedge clk);
    checks++; if (out_valid0 !== 1'b1 || o_alu_out0 !== 32'h72 || o_ctrl0 !== 8'h72) begin
      errors++; $display("FAIL s0_replace got valid=%b alu=%h ctrl=%h exp 1/72/72", out_valid0, o_alu_out0, o_ctrl0);
    end
    in_valid0 = 1'b0;
    @(negedge clk);
    checks++; if (out_valid0 !== 1'b0 || o_ctrl0 !== 8'h00) begin
      errors++; $display("FAIL s0_drain got valid=%b ctrl=%h exp 0/00", out_valid0, o_ctrl0);
    end
  endtask

  initial begin
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    mem_read_data = 32'd0; alu_out = 32'd0; rd = 5'd0; ctrl = 8'd0;
    flush0 = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0;
    mem_read_data0 = 32'd0; alu_out0 = 32'd0; rd0 = 5'd0; ctrl0 = 8'd0;
    test_reset();
    test_bubble();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_skid0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
